// File: rtl/call_scheduler_pkg.sv
// call_scheduler_pkg
// Shared definitions for the hall-call scheduler: floor codes (same encoding
// as the elevator's EA / B1:B0 lines), the scheduler state encoding and small
// helpers that turn a floor code into pending-vector masks and back.
// Pending vectors are always ordered {C,B,A}, so bit index == floor code.
package call_scheduler_pkg;

  localparam logic [1:0] FLR_A   = 2'b00;
  localparam logic [1:0] FLR_B   = 2'b01;
  localparam logic [1:0] FLR_C   = 2'b10;
  localparam logic [1:0] FLR_BAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_UP    = 2'b01,
    S_DOWN  = 2'b10,
    S_DWELL = 2'b11
  } sched_state_t;

  // One-hot pending bit for a floor; the invalid code maps to nothing.
  function automatic logic [2:0] floor_bit(input logic [1:0] f);
    case (f)
      FLR_A:   floor_bit = 3'b001;
      FLR_B:   floor_bit = 3'b010;
      FLR_C:   floor_bit = 3'b100;
      default: floor_bit = 3'b000;
    endcase
  endfunction

  // Floors strictly above f.
  function automatic logic [2:0] above_mask(input logic [1:0] f);
    case (f)
      FLR_A:   above_mask = 3'b110;
      FLR_B:   above_mask = 3'b100;
      default: above_mask = 3'b000;
    endcase
  endfunction

  // Floors strictly below f.
  function automatic logic [2:0] below_mask(input logic [1:0] f);
    case (f)
      FLR_B:   below_mask = 3'b001;
      FLR_C:   below_mask = 3'b011;
      default: below_mask = 3'b000;
    endcase
  endfunction

  // Lowest floor with its bit set (callers guarantee v != 0).
  function automatic logic [1:0] lowest_floor(input logic [2:0] v);
    if (v[0])      lowest_floor = FLR_A;
    else if (v[1]) lowest_floor = FLR_B;
    else           lowest_floor = FLR_C;
  endfunction

  // Highest floor with its bit set (callers guarantee v != 0).
  function automatic logic [1:0] highest_floor(input logic [2:0] v);
    if (v[2])      highest_floor = FLR_C;
    else if (v[1]) highest_floor = FLR_B;
    else           highest_floor = FLR_A;
  endfunction

endpackage

// File: rtl/call_latch.sv
// call_latch
// Rising-edge detection on the three hall buttons plus the pending-call
// register. A held button only counts once; a button already held when reset
// is released is ignored until it is released and pressed again.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   btn      in   {C,B,A} raw button levels, synchronous to clk
//   clr_vec  in   {C,B,A} bits to clear this cycle; a clear beats a same-cycle set
//   set_vec  out  {C,B,A} button edges seen this cycle (combinational)
//   pending  out  {C,B,A} outstanding calls
module call_latch
  import call_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic [2:0] clr_vec,
  output logic [2:0] set_vec,
  output logic [2:0] pending
);

  logic [2:0] btn_prev;
  logic       armed;

  // The history register is zero after reset, so the first cycle out of reset
  // only loads the history; without this a held button would look like a press.
  assign set_vec = armed ? (btn & ~btn_prev) : 3'b000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_prev <= 3'b000;
      armed    <= 1'b0;
      pending  <= 3'b000;
    end else begin
      btn_prev <= btn;
      armed    <= 1'b1;
      pending  <= (pending | set_vec) & ~clr_vec;
    end
  end

endmodule

// File: rtl/call_scheduler.sv
// call_scheduler
// SCAN-style sequencer for the 3-floor elevator hall calls. Latches calls,
// issues the next target floor to the elevator FSM, holds a dwell period at
// each served floor and clears the call once the car arrives.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-low reset
//   call_a/b/c    in   hall buttons, level, may be held
//   floor         in   current floor 00=A 01=B 10=C 11=invalid
//   door_open     in   1 = door open (also covers alarm/overload hold)
//   target        out  floor to travel to (B1:B0 of the elevator)
//   target_valid  out  1 = target is a command, 0 = stand still
//   pending       out  {C,B,A} outstanding calls
//   dir_up        out  scan direction up
//   dir_down      out  scan direction down
//   fault         out  invalid floor code seen, sticky until reset
// Parameters:
//   DWELL_CYC     dwell counter load value (1..15)
//   PREF_UP       from B with calls at both A and C: 1 = go up first
module call_scheduler
  import call_scheduler_pkg::*;
#(
  parameter int unsigned DWELL_CYC = 3,
  parameter bit          PREF_UP   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       call_a,
  input  logic       call_b,
  input  logic       call_c,
  input  logic [1:0] floor,
  input  logic       door_open,
  output logic [1:0] target,
  output logic       target_valid,
  output logic [2:0] pending,
  output logic       dir_up,
  output logic       dir_down,
  output logic       fault
);

  localparam logic [3:0] DWELL_LOAD = DWELL_CYC[3:0];

  sched_state_t state, state_n;
  logic [3:0]   dwell_cnt, dwell_cnt_n;
  logic [1:0]   target_n;
  logic         target_valid_n, dir_up_n, dir_down_n, fault_n;
  logic [2:0]   set_vec, clr_vec;

  logic [2:0]   here, above, below;
  logic         call_here, press_here, up_first;
  logic         launch_up, launch_down, go_idle, arrive;

  call_latch u_latch (
    .clk     (clk),
    .reset   (reset),
    .btn     ({call_c, call_b, call_a}),
    .clr_vec (clr_vec),
    .set_vec (set_vec),
    .pending (pending)
  );

  assign here       = floor_bit(floor);
  assign above      = pending & above_mask(floor);
  assign below      = pending & below_mask(floor);
  assign call_here  = |(pending & here);
  assign press_here = |(set_vec & here);
  // Only from B can calls lie on both sides at equal distance.
  assign up_first   = (|above) && (!(|below) || PREF_UP);

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      dwell_cnt    <= 4'd0;
      target       <= FLR_A;
      target_valid <= 1'b0;
      dir_up       <= 1'b0;
      dir_down     <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_n;
      dwell_cnt    <= dwell_cnt_n;
      target       <= target_n;
      target_valid <= target_valid_n;
      dir_up       <= dir_up_n;
      dir_down     <= dir_down_n;
      fault        <= fault_n;
    end
  end

  // Next-state logic. Each branch only raises an intent flag (launch_up,
  // launch_down, go_idle, arrive); the actions are applied once at the end so
  // IDLE, UP/DOWN and the DWELL exit share the same launch behaviour.
  always_comb begin
    state_n        = state;
    dwell_cnt_n    = dwell_cnt;
    target_n       = target;
    target_valid_n = target_valid;
    dir_up_n       = dir_up;
    dir_down_n     = dir_down;
    fault_n        = fault;
    clr_vec        = 3'b000;
    launch_up      = 1'b0;
    launch_down    = 1'b0;
    go_idle        = 1'b0;
    arrive         = 1'b0;

    if (floor == FLR_BAD) begin
      // Pending calls survive; scheduling restarts from IDLE once the floor
      // code is valid again.
      fault_n        = 1'b1;
      target_valid_n = 1'b0;
      state_n        = S_IDLE;
      dir_up_n       = 1'b0;
      dir_down_n     = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          target_valid_n = 1'b0;
          if (call_here)      arrive      = 1'b1;
          else if (up_first)  launch_up   = 1'b1;
          else if (|below)    launch_down = 1'b1;
        end
        S_UP: begin
          if (target_valid && floor == target) arrive = 1'b1;
          else if (|above) begin
            target_n       = lowest_floor(above);
            target_valid_n = 1'b1;
          end
          else if (call_here) arrive  = 1'b1;
          else                go_idle = 1'b1;
        end
        S_DOWN: begin
          if (target_valid && floor == target) arrive = 1'b1;
          else if (|below) begin
            target_n       = highest_floor(below);
            target_valid_n = 1'b1;
          end
          else if (call_here) arrive  = 1'b1;
          else                go_idle = 1'b1;
        end
        S_DWELL: begin
          target_valid_n = 1'b0;
          // A press at the served floor never latches; it reopens the dwell.
          clr_vec        = here;
          if (press_here)          dwell_cnt_n = DWELL_LOAD;
          else if (door_open)      dwell_cnt_n = dwell_cnt;
          else if (dwell_cnt != 0) dwell_cnt_n = dwell_cnt - 4'd1;
          else if (dir_up) begin
            if (|above)      launch_up   = 1'b1;
            else if (|below) launch_down = 1'b1;
            else             go_idle     = 1'b1;
          end else if (dir_down) begin
            if (|below)      launch_down = 1'b1;
            else if (|above) launch_up   = 1'b1;
            else             go_idle     = 1'b1;
          end else begin
            if (up_first)    launch_up   = 1'b1;
            else if (|below) launch_down = 1'b1;
            else             go_idle     = 1'b1;
          end
        end
        default: go_idle = 1'b1;
      endcase

      if (arrive) begin
        state_n        = S_DWELL;
        clr_vec        = here;
        target_valid_n = 1'b0;
        dwell_cnt_n    = DWELL_LOAD;
      end
      if (launch_up) begin
        state_n        = S_UP;
        target_n       = lowest_floor(above);
        target_valid_n = 1'b1;
        dir_up_n       = 1'b1;
        dir_down_n     = 1'b0;
      end
      if (launch_down) begin
        state_n        = S_DOWN;
        target_n       = highest_floor(below);
        target_valid_n = 1'b1;
        dir_up_n       = 1'b0;
        dir_down_n     = 1'b1;
      end
      if (go_idle) begin
        state_n        = S_IDLE;
        target_valid_n = 1'b0;
        dir_up_n       = 1'b0;
        dir_down_n     = 1'b0;
      end
    end
  end

endmodule
